// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared types and constants for the sequential divider
package seq_restoring_divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// rtl/seq_restoring_divider_subtractor.sv - borrow-select subtractor producing a-b and borrow-out
module borrow_select_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int LO = (N - 1) / 2;
  localparam int HI = N - LO;
  localparam logic [HI:0] HI_ONE = {{HI{1'b0}}, 1'b1};

  logic [LO:0] lo_full;
  logic [HI:0] hi_b0;
  logic [HI:0] hi_b1;
  logic        lo_borrow;

  // Lower half resolves its borrow directly; the upper half is speculated
  // for both borrow-in values so it does not wait on the lower chain.
  assign lo_full   = {1'b0, a[LO-1:0]} - {1'b0, b[LO-1:0]};
  assign lo_borrow = lo_full[LO];
  assign hi_b0     = {1'b0, a[N-1:LO]} - {1'b0, b[N-1:LO]};
  assign hi_b1     = {1'b0, a[N-1:LO]} - {1'b0, b[N-1:LO]} - HI_ONE;

  // Per-bit selection of the speculated upper half on the lower borrow.
  always_comb begin
    diff          = '0;
    diff[LO-1:0]  = lo_full[LO-1:0];
    for (int i = 0; i < HI; i++) begin
      diff[LO+i] = lo_borrow ? hi_b1[i] : hi_b0[i];
    end
    borrow = lo_borrow ? hi_b1[HI] : hi_b0[HI];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] q_reg, q_d;
  logic [WIDTH-1:0] d_reg, d_d;
  // The restored remainder is always below the divisor, so WIDTH bits hold
  // it; only the shifted trial value needs the extra bit.
  logic [WIDTH-1:0] r_reg, r_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             zero_pend, zero_pend_d;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic             dbz_d, done_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic             trial_borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             unused_trial_msb;

  assign r_sh = {r_reg, q_reg[WIDTH-1]};

  borrow_select_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a      (r_sh),
    .b      ({1'b0, d_reg}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  // A successful trial is below the divisor, so its top bit is always zero.
  assign unused_trial_msb = trial[WIDTH];

  assign r_step = trial_borrow ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step = {q_reg[WIDTH-2:0], ~trial_borrow};
  assign busy   = (state == RUN);

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_d     = state;
    q_d         = q_reg;
    d_d         = d_reg;
    r_d         = r_reg;
    cnt_d       = cnt;
    zero_pend_d = zero_pend;
    quo_d       = quotient;
    rem_d       = remainder;
    dbz_d       = div_by_zero;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          state_d = RUN;
          if (divisor == '0) begin
            cnt_d       = '0;
            zero_pend_d = 1'b1;
          end else begin
            cnt_d       = CW'(WIDTH);
            zero_pend_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (zero_pend) begin
          // q_reg still holds the untouched dividend on this path.
          quo_d       = '1;
          rem_d       = q_reg;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
          zero_pend_d = 1'b0;
          state_d     = IDLE;
        end else begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo_d   = q_step;
            rem_d   = r_step;
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      q_reg       <= q_d;
      d_reg       <= d_d;
      r_reg       <= r_d;
      cnt         <= cnt_d;
      zero_pend   <= zero_pend_d;
      quotient    <= quo_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  logic [W:0]   sa = '0;
  logic [W:0]   sb = '0;
  logic [W:0]   s_diff;
  logic         s_borrow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = 0;
  bit cmp_en = 1'b0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  borrow_select_subtractor #(.N(W + 1)) u_sub_chk (
    .a      (sa),
    .b      (sb),
    .diff   (s_diff),
    .borrow (s_borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation finishes a fixed number of clocks after
  // acceptance and yields plain integer division results.
  bit           m_busy = 0;
  bit           m_done = 0;
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0;
  bit           m_dz = 0;
  logic [W-1:0] p_q, p_r;
  bit           p_dz;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_q = '0; m_r = '0; m_dz = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        last_accept = cyc;
        if (divisor == 0) begin
          p_q = '1; p_r = dividend; p_dz = 1; m_left = 1;
        end else begin
          p_q = dividend / divisor; p_r = dividend % divisor; p_dz = 0; m_left = W;
        end
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_quotient", quotient, m_q);
      check("cyc_remainder", remainder, m_r);
      check("cyc_div_by_zero", div_by_zero, m_dz);
    end
  end

  // Caller sits #1 after an edge with busy low; returns #1 after the done edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input bit poke);
    int k;
    bit got;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    check("busy_after_accept", busy, 1);
    got = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin got = 1; break; end
      if (poke && k == 3) begin
        start = 1'b1; dividend = 8'd100; divisor = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (got) check("latency", k, exp_lat);
  endtask

  initial begin
    int acc_a;
    int seen;
    logic [W-1:0] ra, rb;

    // Subtractor alone, exhaustive, while the divider is held in reset.
    for (int i = 0; i < 512; i++) begin
      for (int j = 0; j < 512; j++) begin
        logic [W+1:0] ref_v;
        sa = (W+1)'(i); sb = (W+1)'(j);
        #1;
        ref_v = {1'b0, sa} - {1'b0, sb};
        check("subtractor", {s_borrow, s_diff}, ref_v);
      end
    end

    @(posedge clk); #1;
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 8'd7, 8, 0);
    check("q_200_7", quotient, 28);
    check("r_200_7", remainder, 4);
    check("dz_200_7", div_by_zero, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    run_op(8'd255, 8'd1, 8, 0);
    check("q_255_1", quotient, 255);
    check("r_255_1", remainder, 0);
    run_op(8'd5, 8'd10, 8, 0);
    check("q_5_10", quotient, 0);
    check("r_5_10", remainder, 5);
    run_op(8'd77, 8'd0, 1, 0);
    check("q_77_0", quotient, 255);
    check("r_77_0", remainder, 77);
    check("dz_77_0", div_by_zero, 1);
    run_op(8'd9, 8'd3, 8, 0);
    check("q_9_3", quotient, 3);
    check("r_9_3", remainder, 0);
    check("dz_9_3", div_by_zero, 0);
    @(posedge clk); #1;

    // Start while busy is ignored; start in the done cycle is accepted.
    run_op(8'd200, 8'd7, 8, 1);
    check("q_ignore", quotient, 28);
    check("r_ignore", remainder, 4);
    acc_a = last_accept;
    run_op(8'd100, 8'd9, 8, 0);
    check("b2b_accept_gap", last_accept - acc_a, 9);
    check("q_100_9", quotient, 11);
    check("r_100_9", remainder, 1);
    @(posedge clk); #1;

    // Reset part way through an operation.
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_op(8'd200, 8'd7, 8, 0);
    check("q_after_rst", quotient, 28);
    check("r_after_rst", remainder, 4);

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'd0;
        1: ra = 8'd255;
        2: ra = 8'd1;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rb = 8'd0;
        1: rb = 8'd255;
        2: rb = 8'd1;
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, (rb == 0) ? 1 : 8, 0);
      if (rb != 0) begin
        check("rnd_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
        check("rnd_rem_lt_div", remainder < rb, 1);
      end else begin
        check("rnd_dz_q", quotient, 255);
        check("rnd_dz_r", remainder, ra);
      end
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
